// File: rtl/psum_acc_ctrl.sv
// Read-modify-write accumulation sequencer for one PE's psum scratchpad.
// Optional feature macro: PSUM_SAT_EN (saturating adds with a sticky out_sat flag).
module psum_acc_ctrl #(
  parameter int unsigned PSUM_W = 24,
  parameter int unsigned PROD_W = 16,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_chain,
  output logic              busy,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_data,
  output logic              prod_ready,
  input  logic              psin_valid,
  input  logic [PSUM_W-1:0] psin_data,
  output logic              psin_ready,
  output logic              out_valid,
  output logic [PSUM_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_sat,
  output logic              done,
  output logic              spad_wen,
  output logic [PSUM_W-1:0] spad_wdata,
  output logic              spad_ren,
  input  logic [PSUM_W-1:0] spad_rdata
);

  typedef enum logic [1:0] {StIdle, StAcc, StAdd, StOut} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              chain_q, chain_d;
  logic              start_job;

  logic [PSUM_W:0]   rd_ext, prod_ext, psin_ext, addend, sum;
  logic [PSUM_W-1:0] sum_f;

  // Sums carry one guard bit so overflow is visible before f() is applied.
  assign rd_ext   = {spad_rdata[PSUM_W-1], spad_rdata};
  assign prod_ext = {{(PSUM_W + 1 - PROD_W){prod_data[PROD_W-1]}}, prod_data};
  assign psin_ext = {psin_data[PSUM_W-1], psin_data};
  assign addend   = (state_q == StAdd) ? psin_ext : prod_ext;
  assign sum      = rd_ext + addend;

`ifdef PSUM_SAT_EN
  logic clamp;
  logic sat_q, sat_d;

  always_comb begin
    clamp = 1'b0;
    sum_f = sum[PSUM_W-1:0];
    if (sum[PSUM_W] != sum[PSUM_W-1]) begin
      clamp = 1'b1;
      sum_f = sum[PSUM_W] ? {1'b1, {(PSUM_W - 1){1'b0}}} : {1'b0, {(PSUM_W - 1){1'b1}}};
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (start_job) begin
      sat_d = 1'b0;
    end else if (spad_wen && clamp) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign out_sat = (state_q == StOut) && sat_q;
`else
  logic unused_guard;

  assign unused_guard = sum[PSUM_W];
  assign sum_f        = sum[PSUM_W-1:0];
  assign out_sat      = 1'b0;
`endif

  // Static decodes depend on state only, so spad_rdata never feeds back into spad_ren.
  assign start_job  = (state_q == StIdle) && start;
  assign busy       = (state_q != StIdle);
  assign prod_ready = (state_q == StAcc);
  assign psin_ready = (state_q == StAdd);
  assign out_valid  = (state_q == StOut);
  assign spad_ren   = (state_q == StAcc) || (state_q == StAdd) || (state_q == StOut);
  assign out_data   = (state_q == StOut) ? spad_rdata : '0;
  assign done       = (state_q == StOut) && out_ready;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    len_d      = len_q;
    chain_d    = chain_q;
    spad_wen   = 1'b0;
    spad_wdata = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          spad_wen = 1'b1;
          count_d  = '0;
          len_d    = cfg_len;
          chain_d  = cfg_chain;
          if (cfg_len != '0) begin
            state_d = StAcc;
          end else if (cfg_chain) begin
            state_d = StAdd;
          end else begin
            state_d = StOut;
          end
        end
      end
      StAcc: begin
        if (prod_valid) begin
          spad_wen   = 1'b1;
          spad_wdata = sum_f;
          count_d    = count_q + LEN_W'(1);
          if (count_q == len_q - LEN_W'(1)) begin
            state_d = chain_q ? StAdd : StOut;
          end
        end
      end
      StAdd: begin
        if (psin_valid) begin
          spad_wen   = 1'b1;
          spad_wdata = sum_f;
          state_d    = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      len_q   <= '0;
      chain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      chain_q <= chain_d;
    end
  end

endmodule
